// File: rtl/aemb_sio_pkg.sv
// aemb_sio_pkg: register offsets, bit indices and bus FSM states for the aeMB special-port window.
package aemb_sio_pkg;
    localparam logic [3:0] OFF_TXD    = 4'h0;
    localparam logic [3:0] OFF_COUNT  = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h5;
    localparam logic [3:0] OFF_RELOAD = 4'h6;
    localparam logic [3:0] OFF_ISR    = 4'h8;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IRQ  = 2;
    localparam int ISR_PEND  = 0;
    localparam int ISR_OVF   = 1;
    typedef enum logic {ST_IDLE, ST_ACK} bus_st_t;
endpackage

// File: rtl/aemb_sio_fifo.sv
// aemb_sio_fifo: byte-wide synchronous FIFO with wrap-bit pointers and occupancy count.
module aemb_sio_fifo #(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [PW:0] count
);
    logic [7:0]  mem [DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = count == '0;
    assign full  = count == (PW+1)'(DEPTH);
    // head reads as zero when empty so the output is defined out of reset
    assign dout  = empty ? 8'h00 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge sys_clk_i or posedge sys_rst_i)
        if (sys_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end

    always_ff @(posedge sys_clk_i)
        if (push) mem[wr_ptr[PW-1:0]] <= din;
endmodule

// File: rtl/aemb_dwb_sio.sv
// aemb_dwb_sio: dwb slave exposing stdout FIFO, Timer0 and interrupt status in the top 64 bytes.
module aemb_dwb_sio
    import aemb_sio_pkg::*;
#(
    parameter int AW        = 16,
    parameter int TXD_DEPTH = 8
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic          tx_stb_o,
    output logic [7:0]    tx_dat_o,
    input  logic          tx_ack_i,
    output logic          sys_int_o
);
    localparam int PW = $clog2(TXD_DEPTH);

    bus_st_t     st, st_nxt;
    logic [3:0]  off;
    logic        hit, acc, wr, sel_all;
    logic        wr_txd, wr_cnt, wr_ctrl, wr_rld, wr_isr;
    logic [31:0] cnt, rld, rdata;
    logic [2:0]  ctrl;
    logic        pend, ovf, tc, dec, to_zero, term, set_pend, set_ovf;
    logic        push, pop, full, empty;
    logic [PW:0] fcount;

    assign hit       = &dwb_adr_i[AW-1:6];
    assign off       = dwb_adr_i[5:2];
    assign acc       = dwb_stb_i & hit & (st == ST_IDLE);
    assign dwb_ack_o = st == ST_ACK;
    assign wr        = acc & dwb_wre_i;
    assign sel_all   = &dwb_sel_i;
    assign wr_txd    = wr & (off == OFF_TXD) & dwb_sel_i[3];
    assign wr_cnt    = wr & (off == OFF_COUNT) & sel_all;
    assign wr_ctrl   = wr & (off == OFF_CTRL) & sel_all;
    assign wr_rld    = wr & (off == OFF_RELOAD) & sel_all;
    assign wr_isr    = wr & (off == OFF_ISR);

    always_comb begin
        st_nxt = ST_IDLE;
        if (acc) st_nxt = ST_ACK;
    end

    // tc marks a zero reached by decrement, so the following terminal cycle does not re-raise pending
    assign dec      = ctrl[CTRL_EN] & (cnt != 32'd0);
    assign to_zero  = dec & ~wr_cnt & (cnt == 32'd1);
    assign term     = ctrl[CTRL_EN] & (cnt == 32'd0) & ~wr_cnt;
    assign set_pend = to_zero | (term & ~tc);

    assign pop      = tx_stb_o & tx_ack_i;
    assign push     = wr_txd & (~full | pop);
    assign set_ovf  = wr_txd & full & ~pop;
    assign tx_stb_o = ~empty;

    always_comb begin
        rdata = '0;
        rdata = (off == OFF_TXD)    ? {ovf, full, empty, 21'b0, 8'(fcount)} :
                (off == OFF_COUNT)  ? cnt :
                (off == OFF_CTRL)   ? {29'b0, ctrl} :
                (off == OFF_RELOAD) ? rld :
                (off == OFF_ISR)    ? {30'b0, ovf, pend} : 32'd0;
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i)
        st <= sys_rst_i ? ST_IDLE : st_nxt;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i)
        if (sys_rst_i) begin
            dwb_dat_o <= '0;
            cnt       <= '0;
            rld       <= '0;
            ctrl      <= '0;
            pend      <= 1'b0;
            ovf       <= 1'b0;
            tc        <= 1'b0;
            sys_int_o <= 1'b0;
        end else begin
            dwb_dat_o <= (acc & ~dwb_wre_i) ? rdata : 32'd0;
            cnt       <= wr_cnt ? dwb_dat_i :
                         term   ? (ctrl[CTRL_AUTO] ? rld : cnt) :
                         dec    ? cnt - 32'd1 : cnt;
            if (wr_ctrl) ctrl <= dwb_dat_i[2:0];
            else if (term & ~ctrl[CTRL_AUTO]) ctrl[CTRL_EN] <= 1'b0;
            if (wr_rld) rld <= dwb_dat_i;
            tc        <= to_zero;
            pend      <= set_pend | (pend & ~(wr_isr & dwb_dat_i[ISR_PEND]));
            ovf       <= set_ovf | (ovf & ~(wr_isr & dwb_dat_i[ISR_OVF]));
            sys_int_o <= pend & ctrl[CTRL_IRQ];
        end

    aemb_sio_fifo #(.DEPTH(TXD_DEPTH)) u_fifo (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .push      (push),
        .pop       (pop),
        .din       (dwb_dat_i[31:24]),
        .dout      (tx_dat_o),
        .full      (full),
        .empty     (empty),
        .count     (fcount)
    );
endmodule

// File: tb/tb_aemb_dwb_sio.sv
// tb_aemb_dwb_sio: directed and random bus traffic checked cycle by cycle against a behavioural model.
module tb_aemb_dwb_sio;
    localparam int AW = 16;
    localparam int DEPTH = 8;

    logic          sys_clk_i = 1'b0;
    logic          sys_rst_i = 1'b1;
    logic          dwb_stb_i = 1'b0;
    logic          dwb_wre_i = 1'b0;
    logic [3:0]    dwb_sel_i = '0;
    logic [AW-1:2] dwb_adr_i = '0;
    logic [31:0]   dwb_dat_i = '0;
    logic [31:0]   dwb_dat_o;
    logic          dwb_ack_o, tx_stb_o, sys_int_o;
    logic [7:0]    tx_dat_o;
    logic          tx_ack_i = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_cnt, m_rld, m_dat;
    logic        m_en, m_auto, m_irq, m_pend, m_ovf, m_armed, m_ack, m_int;
    logic [7:0]  m_q[$];

    always #5 sys_clk_i = ~sys_clk_i;

    aemb_dwb_sio #(.AW(AW), .TXD_DEPTH(DEPTH)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .dwb_stb_i (dwb_stb_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_adr_i (dwb_adr_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_dat_o (dwb_dat_o),
        .dwb_ack_o (dwb_ack_o),
        .tx_stb_o  (tx_stb_o),
        .tx_dat_o  (tx_dat_o),
        .tx_ack_i  (tx_ack_i),
        .sys_int_o (sys_int_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rld = 0; m_dat = 0;
        {m_en, m_auto, m_irq, m_pend, m_ovf, m_armed, m_ack, m_int} = '0;
        m_q.delete();
    endtask

    // One clock: predict the post-edge state from the spec rules, advance, compare all outputs.
    task automatic tick();
        logic [3:0]  off;
        logic [31:0] d, rd, n_cnt, n_rld;
        logic        acc, wr, pop, full, pset, oset, wisr, n_en, n_auto, n_irq, n_armed, n_int;
        logic [7:0]  head;
        off  = dwb_adr_i[5:2];
        d    = dwb_dat_i;
        acc  = dwb_stb_i && (&dwb_adr_i[AW-1:6]) && !m_ack;
        wr   = acc && dwb_wre_i;
        full = m_q.size() == DEPTH;
        pop  = m_q.size() > 0 && tx_ack_i;
        rd   = 0;
        if (acc && !dwb_wre_i)
            case (off)
                4'h0: rd = {m_ovf, full, m_q.size() == 0, 21'b0, 8'(m_q.size())};
                4'h4: rd = m_cnt;
                4'h5: rd = {29'b0, m_irq, m_auto, m_en};
                4'h6: rd = m_rld;
                4'h8: rd = {30'b0, m_ovf, m_pend};
                default: rd = 0;
            endcase
        oset = 0;
        if (pop) void'(m_q.pop_front());
        if (wr && off == 4'h0 && dwb_sel_i[3]) begin
            if (!full || pop) m_q.push_back(d[31:24]);
            else oset = 1;
        end
        pset = 0; n_armed = 0;
        n_cnt = m_cnt; n_rld = m_rld; n_en = m_en; n_auto = m_auto; n_irq = m_irq;
        if (wr && off == 4'h4 && dwb_sel_i == 4'hF) n_cnt = d;
        else if (m_en && m_cnt == 0) begin
            pset = !m_armed;
            if (m_auto) n_cnt = m_rld;
            else n_en = 0;
        end else if (m_en) begin
            n_cnt = m_cnt - 1;
            n_armed = n_cnt == 0;
            pset = n_armed;
        end
        if (wr && off == 4'h5 && dwb_sel_i == 4'hF) {n_irq, n_auto, n_en} = d[2:0];
        if (wr && off == 4'h6 && dwb_sel_i == 4'hF) n_rld = d;
        wisr = wr && off == 4'h8;
        n_int = m_pend && m_irq;
        @(posedge sys_clk_i);
        #1;
        m_int = n_int;
        m_pend = pset || (m_pend && !(wisr && d[0]));
        m_ovf = oset || (m_ovf && !(wisr && d[1]));
        m_cnt = n_cnt; m_rld = n_rld; m_en = n_en; m_auto = n_auto; m_irq = n_irq;
        m_armed = n_armed; m_ack = acc; m_dat = rd;
        head = m_q.size() > 0 ? m_q[0] : 8'h00;
        check("cycle", {dwb_ack_o, dwb_dat_o, tx_stb_o, tx_dat_o, sys_int_o},
              {m_ack, m_dat, m_q.size() > 0, head, m_int});
    endtask

    task automatic bus(input logic we, input logic [3:0] o, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] q);
        dwb_stb_i = 1; dwb_wre_i = we; dwb_adr_i = {10'h3FF, o}; dwb_dat_i = d; dwb_sel_i = s;
        tick();
        q = dwb_dat_o;
        dwb_stb_i = 0; dwb_wre_i = 0; dwb_sel_i = 0; dwb_dat_i = 0;
        tick();
    endtask

    task automatic wrs(input logic [3:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        bus(1'b1, o, d, s, q);
    endtask

    task automatic wr(input logic [3:0] o, input logic [31:0] d);
        wrs(o, d, 4'hF);
    endtask

    task automatic rd(input logic [3:0] o, output logic [31:0] q);
        bus(1'b0, o, 32'd0, 4'hF, q);
    endtask

    task automatic do_reset();
        #2 sys_rst_i = 1;
        #1;
        model_reset();
        check("rst_ack", dwb_ack_o, 0);
        check("rst_outs", {dwb_dat_o, tx_stb_o, tx_dat_o, sys_int_o}, 0);
        dwb_stb_i = 0; dwb_wre_i = 0; dwb_sel_i = 0;
        @(posedge sys_clk_i);
        #1 sys_rst_i = 0;
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        #1;
        check("reset_state", {dwb_ack_o, dwb_dat_o, tx_stb_o, tx_dat_o, sys_int_o}, 0);
        @(posedge sys_clk_i);
        #1 sys_rst_i = 0;

        // single TXD byte, consumer ready: visible for exactly one beat
        tx_ack_i = 1;
        dwb_stb_i = 1; dwb_wre_i = 1; dwb_adr_i = {10'h3FF, 4'h0}; dwb_dat_i = 32'h4100_0000; dwb_sel_i = 4'h8;
        tick();
        check("t1_ack", dwb_ack_o, 1);
        check("t1_txd", {tx_stb_o, tx_dat_o}, {1'b1, 8'h41});
        dwb_stb_i = 0; dwb_wre_i = 0; dwb_sel_i = 0; dwb_dat_i = 0;
        tick();
        check("t1_beat", tx_stb_o, 0);

        // overfill the FIFO with the consumer stalled
        tx_ack_i = 0;
        for (int i = 0; i < 9; i++) wrs(4'h0, {8'(i + 1), 24'h0}, 4'h8);
        rd(4'h0, v);
        check("t2_status", v, 32'hC000_0008);
        tx_ack_i = 1;
        for (int i = 0; i < 8; i++) begin
            check("t2_byte", tx_dat_o, i + 1);
            tick();
        end
        check("t2_drained", tx_stb_o, 0);
        tx_ack_i = 0;
        wr(4'h8, 32'h2);
        rd(4'h0, v);
        check("t2_clear", v, 32'h2000_0000);

        // one-shot timer with interrupt
        wr(4'h4, 5);
        wr(4'h5, 5);
        repeat (4) tick();
        check("t3_int_early", sys_int_o, 0);
        tick();
        check("t3_int", sys_int_o, 1);
        rd(4'h8, v);
        check("t3_isr", v, 1);
        wr(4'h8, 1);
        check("t3_int_clr", sys_int_o, 0);
        rd(4'h5, v);
        check("t3_en_cleared", v, 4);

        // periodic auto-reload
        wr(4'h6, 3);
        wr(4'h4, 2);
        wr(4'h5, 7);
        for (int i = 0; i < 6; i++) begin
            rd(4'h4, v);
            check("t4_range", v <= 3, 1);
        end
        rd(4'h8, v);
        check("t4_pend", v[0], 1);
        wr(4'h5, 0);
        wr(4'h8, 3);

        // terminal count racing a W1C, then racing a COUNT write
        wr(4'h4, 2);
        wr(4'h5, 1);
        wr(4'h8, 1);
        rd(4'h8, v);
        check("t5_set_wins", v[0], 1);
        wr(4'h8, 1);
        wr(4'h4, 2);
        wr(4'h5, 1);
        wr(4'h4, 100);
        wr(4'h5, 0);
        rd(4'h8, v);
        check("t5_write_wins", v[0], 0);

        // miss never acks; reset mid-transaction clears everything
        dwb_stb_i = 1; dwb_wre_i = 0; dwb_adr_i = {10'h155, 4'h4};
        repeat (4) begin
            tick();
            check("t6_miss", dwb_ack_o, 0);
        end
        dwb_stb_i = 0;
        tick();
        wr(4'h6, 77);
        wr(4'h4, 50);
        wr(4'h5, 5);
        wrs(4'h0, 32'h5A00_0000, 4'h8);
        dwb_stb_i = 1; dwb_adr_i = {10'h3FF, 4'h5};
        tick();
        do_reset();
        rd(4'h4, v); check("t6_count", v, 0);
        rd(4'h5, v); check("t6_ctrl", v, 0);
        rd(4'h6, v); check("t6_reload", v, 0);
        rd(4'h8, v); check("t6_isr", v, 0);
        rd(4'h0, v); check("t6_txd", v, 32'h2000_0000);

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 10);
            tx_ack_i = 1'($urandom_range(0, 1));
            case (r)
                0, 1: wrs(4'h0, $urandom, ($urandom_range(0, 2) != 0) ? 4'h8 : 4'($urandom));
                2: wr(4'h4, $urandom_range(0, 12));
                3: wr(4'h5, $urandom_range(0, 7));
                4: wr(4'h6, $urandom_range(0, 6));
                5: wr(4'h8, $urandom_range(0, 3));
                6: rd(4'($urandom), v);
                7: wrs(4'($urandom), $urandom, 4'($urandom));
                8: rd(($urandom_range(0, 1) != 0) ? 4'h4 : 4'h8, v);
                9: begin
                    dwb_stb_i = 1; dwb_wre_i = 1'($urandom);
                    dwb_adr_i = {1'b0, 9'($urandom), 4'($urandom)};
                    tick();
                    dwb_stb_i = 0; dwb_wre_i = 0;
                end
                default: tick();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
